// File: rtl/exp_fifo_wrapper_if.sv
// Operand, engine and FIFO-read signals of exp_fifo_wrapper, grouped for port connection.
interface exp_fifo_wrapper_if #(
  parameter int VW    = 16,
  parameter int IW    = 2,
  parameter int FW    = 16,
  parameter int SW    = 2,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = IW + FW + (1 << SW) - 1;

  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] v;
  logic [SW-1:0] u;
  logic          eng_start;
  logic [VW-1:0] eng_x;
  logic          eng_done;
  logic [IW-1:0] eng_int;
  logic [FW-1:0] eng_frac;
  logic          rd_req;
  logic [OW-1:0] q;
  logic          empty;
  logic          full;
  logic [AW:0]   usedw;
  logic          flush;
  logic          drop_flag;

  modport master (
    output in_valid, v, u, eng_done, eng_int, eng_frac, rd_req, flush,
    input  in_ready, eng_start, eng_x, q, empty, full, usedw, drop_flag
  );

  modport slave (
    input  in_valid, v, u, eng_done, eng_int, eng_frac, rd_req, flush,
    output in_ready, eng_start, eng_x, q, empty, full, usedw, drop_flag
  );
endinterface

// File: rtl/exp_fifo_wrapper.sv
// Sequences one operand through an external engine, shifts the result and queues it in a FIFO.
// Latency: 3 edges plus engine latency to usedw; a full FIFO either stalls in WRITE or drops (STALL).
module exp_fifo_wrapper #(
  parameter int VW    = 16,
  parameter int IW    = 2,
  parameter int FW    = 16,
  parameter int SW    = 2,
  parameter int DEPTH = 4,
  parameter bit STALL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  exp_fifo_wrapper_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = IW + FW + (1 << SW) - 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, WRITE} state_t;

  state_t        state, state_nxt;
  logic [VW-1:0] eng_x_q;
  logic [SW-1:0] sh_q;
  logic [OW-1:0] word_q;
  logic [OW-1:0] shifted;
  logic          drop_q;

  logic [OW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic [OW-1:0] q_q;

  logic empty, full, rd_ok, rd_en, space, wr_go, wr_en;
  logic accept, capture, drop, in_ready, eng_start;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign rd_ok   = bus.rd_req && !empty;
  assign rd_en   = rd_ok && !bus.flush;
  assign space   = !full || rd_ok;
  assign wr_en   = wr_go && !bus.flush;
  assign shifted = {{(OW-IW-FW){1'b0}}, bus.eng_int, bus.eng_frac} << sh_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    wr_go     = 1'b0;
    drop      = 1'b0;
    in_ready  = 1'b0;
    eng_start = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        eng_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.eng_done) begin
          capture   = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        // flush does not alter the FSM: a write swallowed by flush still completes the operation
        if (space) begin
          wr_go     = 1'b1;
          state_nxt = IDLE;
        end else if (!STALL) begin
          drop      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eng_x_q <= '0;
      sh_q    <= '0;
      word_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      if (accept) begin
        eng_x_q <= bus.v;
        sh_q    <= bus.u;
      end
      if (capture) word_q <= shifted;
      if (drop)    drop_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= word_q;
  end

  // Pointers are AW bits wide, so increments wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      q_q <= '0;
    end else if (bus.flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) wp <= wp + AW'(1);
      if (rd_en) begin
        rp  <= rp + AW'(1);
        q_q <= mem[rp];
      end
      cnt <= cnt + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.eng_start = eng_start;
  assign bus.eng_x     = eng_x_q;
  assign bus.q         = q_q;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.usedw     = cnt;
  assign bus.drop_flag = drop_q;
endmodule

// File: tb/tb_exp_fifo_wrapper.sv
// Scoreboard bench: instance 0 stalls on a full FIFO, instance 1 drops; popped words are checked by a monitor.
module tb_exp_fifo_wrapper;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid_d [2];
  logic [15:0] v_d        [2];
  logic [1:0]  u_d        [2];
  logic        eng_done_d [2];
  logic [1:0]  eng_int_d  [2];
  logic [15:0] eng_frac_d [2];
  logic        rd_req_d   [2];
  logic        flush_d    [2];

  logic        in_ready_o  [2];
  logic        eng_start_o [2];
  logic [15:0] eng_x_o     [2];
  logic [20:0] q_o         [2];
  logic        empty_o     [2];
  logic        full_o      [2];
  logic [2:0]  usedw_o     [2];
  logic        drop_o      [2];

  exp_fifo_wrapper_if #(.VW(16), .IW(2), .FW(16), .SW(2), .DEPTH(4)) if0 ();
  exp_fifo_wrapper_if #(.VW(16), .IW(2), .FW(16), .SW(2), .DEPTH(4)) if1 ();

  exp_fifo_wrapper #(.VW(16), .IW(2), .FW(16), .SW(2), .DEPTH(4), .STALL(1'b1)) u_stall (
    .clk(clk), .rst(rst_n), .bus(if0)
  );
  exp_fifo_wrapper #(.VW(16), .IW(2), .FW(16), .SW(2), .DEPTH(4), .STALL(1'b0)) u_drop (
    .clk(clk), .rst(rst_n), .bus(if1)
  );

  assign if0.in_valid = in_valid_d[0];
  assign if0.v        = v_d[0];
  assign if0.u        = u_d[0];
  assign if0.eng_done = eng_done_d[0];
  assign if0.eng_int  = eng_int_d[0];
  assign if0.eng_frac = eng_frac_d[0];
  assign if0.rd_req   = rd_req_d[0];
  assign if0.flush    = flush_d[0];
  assign if1.in_valid = in_valid_d[1];
  assign if1.v        = v_d[1];
  assign if1.u        = u_d[1];
  assign if1.eng_done = eng_done_d[1];
  assign if1.eng_int  = eng_int_d[1];
  assign if1.eng_frac = eng_frac_d[1];
  assign if1.rd_req   = rd_req_d[1];
  assign if1.flush    = flush_d[1];

  assign in_ready_o[0]  = if0.in_ready;
  assign eng_start_o[0] = if0.eng_start;
  assign eng_x_o[0]     = if0.eng_x;
  assign q_o[0]         = if0.q;
  assign empty_o[0]     = if0.empty;
  assign full_o[0]      = if0.full;
  assign usedw_o[0]     = if0.usedw;
  assign drop_o[0]      = if0.drop_flag;
  assign in_ready_o[1]  = if1.in_ready;
  assign eng_start_o[1] = if1.eng_start;
  assign eng_x_o[1]     = if1.eng_x;
  assign q_o[1]         = if1.q;
  assign empty_o[1]     = if1.empty;
  assign full_o[1]      = if1.full;
  assign usedw_o[1]     = if1.usedw;
  assign drop_o[1]      = if1.drop_flag;

  int n_checks = 0;
  int n_fail   = 0;
  logic [20:0] exp0 [$];
  logic [20:0] exp1 [$];
  logic pend [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_exp(input int d, input logic [20:0] val);
    if (d == 0) exp0.push_back(val);
    else        exp1.push_back(val);
  endtask

  // Monitor: a pop is registered at the edge, so q is compared at the following negedge.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      pend[d] = rst_n && rd_req_d[d] && !empty_o[d] && !flush_d[d];
  end

  always @(negedge clk) begin
    logic [20:0] ev;
    for (int d = 0; d < 2; d++) begin
      if (pend[d]) begin
        if ((d == 0 && exp0.size() == 0) || (d == 1 && exp1.size() == 0)) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop dut%0d: got q=%0h, expected no pop", d, q_o[d]);
        end else begin
          ev = (d == 0) ? exp0.pop_front() : exp1.pop_front();
          chk($sformatf("pop_q dut%0d", d), 32'(q_o[d]), 32'(ev));
        end
      end
    end
  end

  // One full operation; returns at the negedge right after the result capture (FSM in WRITE).
  task automatic op(input int d, input logic [15:0] vv, input logic [1:0] uu, input logic [1:0] ii,
                    input logic [15:0] ff, input logic [20:0] ex, input bit keep, input int lat);
    int n;
    n = 0;
    while (!in_ready_o[d] && n < 50) begin tick(); n++; end
    chk("in_ready_wait", 32'(in_ready_o[d]), 32'd1);
    in_valid_d[d] = 1'b1;
    v_d[d] = vv;
    u_d[d] = uu;
    tick();
    in_valid_d[d] = 1'b0;
    v_d[d] = ~vv;
    n = 0;
    while (!eng_start_o[d] && n < 50) begin tick(); n++; end
    chk("eng_start_seen", 32'(eng_start_o[d]), 32'd1);
    chk("eng_x_latched", 32'(eng_x_o[d]), 32'(vv));
    tick();
    chk("eng_start_one_cycle", 32'(eng_start_o[d]), 32'd0);
    repeat (lat) tick();
    chk("eng_x_stable", 32'(eng_x_o[d]), 32'(vv));
    eng_done_d[d] = 1'b1;
    eng_int_d[d]  = ii;
    eng_frac_d[d] = ff;
    tick();
    eng_done_d[d] = 1'b0;
    if (keep) push_exp(d, ex);
  endtask

  task automatic pop(input int d);
    rd_req_d[d] = 1'b1;
    tick();
    rd_req_d[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [20:0] sweep [4];
    sweep[0] = 21'h03FFFF;
    sweep[1] = 21'h07FFFE;
    sweep[2] = 21'h0FFFFC;
    sweep[3] = 21'h1FFFF8;
    for (int d = 0; d < 2; d++) begin
      in_valid_d[d] = 1'b0; v_d[d] = '0; u_d[d] = '0; eng_done_d[d] = 1'b0;
      eng_int_d[d] = '0; eng_frac_d[d] = '0; rd_req_d[d] = 1'b0; flush_d[d] = 1'b0;
      pend[d] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_empty", 32'(empty_o[d]), 32'd1);
      chk("rst_full", 32'(full_o[d]), 32'd0);
      chk("rst_usedw", 32'(usedw_o[d]), 32'd0);
      chk("rst_in_ready", 32'(in_ready_o[d]), 32'd1);
      chk("rst_drop", 32'(drop_o[d]), 32'd0);
      chk("rst_q", 32'(q_o[d]), 32'd0);
      chk("rst_eng_x", 32'(eng_x_o[d]), 32'd0);
      chk("rst_eng_start", 32'(eng_start_o[d]), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Single operation, zero engine latency: usedw rises on the third edge after capture-ready.
    op(0, 16'h1234, 2'd2, 2'b01, 16'h8000, 21'h060000, 1'b1, 0);
    chk("lat_usedw_before", 32'(usedw_o[0]), 32'd0);
    tick();
    chk("lat_usedw_after", 32'(usedw_o[0]), 32'd1);
    chk("single_not_empty", 32'(empty_o[0]), 32'd0);
    pop(0);
    chk("single_usedw_0", 32'(usedw_o[0]), 32'd0);

    // Shift sweep fills the stalling FIFO; a fifth result then holds in WRITE.
    for (int k = 0; k < 4; k++)
      op(0, 16'h0F00 + 16'(k), 2'(k), 2'b11, 16'hFFFF, sweep[k], 1'b1, 2);
    tick();
    chk("fill_full", 32'(full_o[0]), 32'd1);
    chk("fill_usedw", 32'(usedw_o[0]), 32'd4);
    op(0, 16'hABCD, 2'd0, 2'b10, 16'h0001, 21'h020001, 1'b1, 1);
    repeat (2) tick();
    chk("stall_in_ready", 32'(in_ready_o[0]), 32'd0);
    chk("stall_usedw", 32'(usedw_o[0]), 32'd4);
    pop(0);
    chk("stall_rw_usedw", 32'(usedw_o[0]), 32'd4);
    chk("stall_rw_full", 32'(full_o[0]), 32'd1);
    chk("stall_released", 32'(in_ready_o[0]), 32'd1);
    repeat (4) pop(0);
    chk("drain_empty", 32'(empty_o[0]), 32'd1);

    // Dropping instance: fifth result is discarded and flagged.
    for (int k = 0; k < 4; k++)
      op(1, 16'h2000 + 16'(k), 2'd0, 2'b00, 16'h0010 + 16'(k), 21'h000010 + 21'(k), 1'b1, 0);
    tick();
    chk("drop_full", 32'(full_o[1]), 32'd1);
    chk("drop_flag_before", 32'(drop_o[1]), 32'd0);
    op(1, 16'h3333, 2'd1, 2'b11, 16'hDEAD, 21'h0, 1'b0, 0);
    tick();
    chk("drop_flag_set", 32'(drop_o[1]), 32'd1);
    chk("drop_usedw", 32'(usedw_o[1]), 32'd4);
    chk("drop_in_ready", 32'(in_ready_o[1]), 32'd1);
    repeat (4) pop(1);
    chk("drop_flag_sticky", 32'(drop_o[1]), 32'd1);
    chk("drop_drained", 32'(usedw_o[1]), 32'd0);

    // Wrap-around: pointers cross the DEPTH boundary several times.
    for (int k = 0; k < 10; k++) begin
      op(0, 16'h5000 + 16'(k), 2'd1, 2'b00, 16'h0100 + 16'(k), 21'h000200 + 21'(2 * k), 1'b1, 1);
      tick();
      pop(0);
    end
    pop(0);
    chk("empty_rd_q_hold", 32'(q_o[0]), 32'h212);
    chk("empty_rd_usedw", 32'(usedw_o[0]), 32'd0);

    // Reset while waiting for the engine; a late eng_done must be ignored.
    in_valid_d[0] = 1'b1;
    v_d[0] = 16'h7777;
    u_d[0] = 2'd1;
    tick();
    in_valid_d[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    eng_done_d[0] = 1'b1;
    eng_int_d[0]  = 2'b11;
    eng_frac_d[0] = 16'h1111;
    tick();
    eng_done_d[0] = 1'b0;
    repeat (2) tick();
    chk("rstmid_idle", 32'(in_ready_o[0]), 32'd1);
    chk("rstmid_usedw", 32'(usedw_o[0]), 32'd0);
    chk("rstmid_empty", 32'(empty_o[0]), 32'd1);
    chk("rstmid_eng_x", 32'(eng_x_o[0]), 32'd0);
    chk("rst_clears_drop", 32'(drop_o[1]), 32'd0);

    // Flush coinciding with a write wins.
    for (int k = 0; k < 3; k++)
      op(0, 16'h6000 + 16'(k), 2'd0, 2'b01, 16'(k), 21'h010000 + 21'(k), 1'b1, 0);
    tick();
    chk("pre_flush_usedw", 32'(usedw_o[0]), 32'd3);
    op(0, 16'h6003, 2'd0, 2'b01, 16'h0003, 21'h0, 1'b0, 0);
    flush_d[0] = 1'b1;
    tick();
    flush_d[0] = 1'b0;
    exp0.delete();
    chk("flush_usedw", 32'(usedw_o[0]), 32'd0);
    chk("flush_empty", 32'(empty_o[0]), 32'd1);
    chk("flush_fsm_idle", 32'(in_ready_o[0]), 32'd1);
    op(0, 16'h6004, 2'd3, 2'b00, 16'h0001, 21'h000008, 1'b1, 0);
    tick();
    pop(0);
    tick();
    chk("sb_drained0", 32'(exp0.size()), 32'd0);
    chk("sb_drained1", 32'(exp1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
